fmap_row_streamer: RTL and testbench

// Read-side counterpart of the parallel feature-map buffer. Captures a full
// H x W map in one cycle through a valid/ready handshake, then streams it
// out one row (W elements) per beat, row 0 first, under valid/ready flow

---
 rtl/fmap_row_streamer.sv | 96 +++++++++
 tb/tb_fmap_row_streamer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_row_streamer.sv
// Captures a full H x W feature map in one handshake and streams it out one row per beat.
// A new map may be accepted on the same cycle the last row of the current map is taken.
module fmap_row_streamer #(
  parameter  int DATA_WIDTH = 24,
  parameter  int H          = 14,
  parameter  int W          = 13,
  localparam int RW         = (H > 1) ? $clog2(H) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data [0:H-1][0:W-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data [0:W-1],
  output logic [RW-1:0]         out_row,
  output logic                  out_last,
  output logic                  frame_done
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                  state, state_next;
  logic [RW-1:0]           row_cnt, row_next;
  logic [DATA_WIDTH-1:0]   storage [0:H-1][0:W-1];
  logic                    beat;
  logic                    accept;

  assign out_valid = (state == STREAM);
  assign out_last  = (row_cnt == RW'(H - 1));
  assign out_row   = row_cnt;
  assign out_data  = storage[row_cnt];
  assign beat      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      row_cnt    <= row_next;
      frame_done <= beat && out_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < H; i++) begin
        for (int unsigned j = 0; j < W; j++) begin
          storage[i][j] <= '0;
        end
      end
    end else if (accept) begin
      storage <= in_data;
    end
  end

  // in_ready opens during STREAM only on the final beat, so the next map
  // overwrites storage exactly as the last row leaves.
  always_comb begin
    state_next = state;
    row_next   = row_cnt;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = STREAM;
          row_next   = '0;
        end
      end
      STREAM: begin
        if (beat) begin
          if (out_last) begin
            in_ready   = 1'b1;
            row_next   = '0;
            state_next = in_valid ? STREAM : IDLE;
          end else begin
            row_next = row_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        row_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fmap_row_streamer.sv
// Bench for fmap_row_streamer: queue-of-rows model checked every cycle, plus
// directed literal checks on a 14x13 instance and a 1x1 instance.
module tb_fmap_row_streamer;

  localparam int DW = 24;
  localparam int H  = 14;
  localparam int W  = 13;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
  logic [DW-1:0] in_data  [0:H-1][0:W-1];
  logic [DW-1:0] out_data [0:W-1];
  logic [3:0]    out_row;

  logic          u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_out_last, u_frame_done;
  logic [DW-1:0] u_in_data  [0:0][0:0];
  logic [DW-1:0] u_out_data [0:0];
  logic [0:0]    u_out_row;

  int tests = 0;
  int fails = 0;

  fmap_row_streamer #(.DATA_WIDTH(DW), .H(H), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .frame_done(frame_done)
  );

  fmap_row_streamer #(.DATA_WIDTH(DW), .H(1), .W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .in_data(u_in_data), .out_valid(u_out_valid), .out_ready(u_out_ready),
    .out_data(u_out_data), .out_row(u_out_row), .out_last(u_out_last),
    .frame_done(u_frame_done)
  );

  task automatic chk(input string name, input logic [DW*W-1:0] act, input logic [DW*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of rows still owed to the consumer.
  logic [DW*W-1:0] q_data [$];
  int              q_row  [$];
  logic            fd_exp = 1'b0;

  always @(negedge clk) begin
    logic            ev, el, eb, er, fd_next;
    logic [DW*W-1:0] act_row, new_row;
    if (!rst_n) begin
      q_data.delete();
      q_row.delete();
      fd_exp = 1'b0;
    end
    ev = (q_row.size() > 0);
    el = ev && (q_row[0] == H - 1);
    eb = ev && out_ready;
    er = !ev || (eb && el);
    chk("m_out_valid", {{(DW*W-1){1'b0}}, out_valid}, {{(DW*W-1){1'b0}}, ev});
    chk("m_in_ready", {{(DW*W-1){1'b0}}, in_ready}, {{(DW*W-1){1'b0}}, er});
    chk("m_frame_done", {{(DW*W-1){1'b0}}, frame_done}, {{(DW*W-1){1'b0}}, fd_exp});
    if (!rst_n) chk("m_rst_row", {{(DW*W-4){1'b0}}, out_row}, '0);
    if (ev) begin
      for (int j = 0; j < W; j++) act_row[j*DW +: DW] = out_data[j];
      chk("m_out_row", {{(DW*W-4){1'b0}}, out_row}, (DW*W)'(q_row[0]));
      chk("m_out_last", {{(DW*W-1){1'b0}}, out_last}, {{(DW*W-1){1'b0}}, el});
      chk("m_out_data", act_row, q_data[0]);
    end
    if (rst_n) begin
      fd_next = eb && el;
      if (eb) begin
        void'(q_data.pop_front());
        void'(q_row.pop_front());
      end
      if (in_valid && er) begin
        for (int i = 0; i < H; i++) begin
          for (int j = 0; j < W; j++) new_row[j*DW +: DW] = in_data[i][j];
          q_data.push_back(new_row);
          q_row.push_back(i);
        end
      end
      fd_exp = fd_next;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        in_data[i][j] = base + DW'(i * 16 + j);
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!out_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", {{(DW*W-1){1'b0}}, done}, 1);
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fill('0);
    u_in_valid = 1'b0; u_out_ready = 1'b0; u_in_data[0][0] = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_data0", out_data[0], 0);
    step(); rst_n = 1'b1;

    // Single frame at full rate
    step(); fill('0); in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    for (int r = 0; r < H; r++) begin
      @(negedge clk);
      chk("t2_row", out_row, r);
      chk("t2_last", out_last, (r == H - 1) ? 1 : 0);
      chk("t2_data1", out_data[1], r * 16 + 1);
      if (r == H - 1) chk("t2_data12", out_data[12], 24'd220);
      step();
    end
    @(negedge clk);
    chk("t2_frame_done", frame_done, 1);
    chk("t2_idle", out_valid, 0);
    step();

    // Backpressure on row 5
    fill('0); in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    repeat (5) step();
    out_ready = 1'b0;
    @(negedge clk); chk("t3_hold_a", out_row, 5);
    step();
    @(negedge clk); chk("t3_hold_b", out_row, 5); chk("t3_hold_data", out_data[2], 24'h52);
    step(); out_ready = 1'b1;
    @(negedge clk); chk("t3_hold_c", out_row, 5);
    step();
    @(negedge clk); chk("t3_next", out_row, 6);
    wait_idle();

    // Back-to-back frames with in_valid held
    fill('0); in_valid = 1'b1; out_ready = 1'b1;
    step(); fill(24'h100000);
    for (int r = 0; r < H; r++) begin
      @(negedge clk);
      chk("t4_in_ready", in_ready, (r == H - 1) ? 1 : 0);
      chk("t4_a_data0", out_data[0], r * 16);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_b_valid", out_valid, 1);
    chk("t4_b_row", out_row, 0);
    chk("t4_b_data0", out_data[0], 24'h100000);
    chk("t4_a_done", frame_done, 1);
    wait_idle();

    // Load attempt mid-frame is refused
    fill('0); in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    repeat (3) step();
    fill(24'h200000); in_valid = 1'b1;
    @(negedge clk);
    chk("t5_refused", in_ready, 0);
    chk("t5_row3", out_row, 3);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("t5_row4_data", out_data[0], 24'h40);
    wait_idle();

    // Reset mid-stream
    fill('0); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_out_valid", out_valid, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_out_row", out_row, 0);
    chk("t1_frame_done", frame_done, 0);
    step(); rst_n = 1'b1;
    step();

    // H=1, W=1 instance
    u_in_data[0][0] = 24'hABCDEF; u_in_valid = 1'b1; u_out_ready = 1'b1;
    step(); u_in_valid = 1'b0;
    @(negedge clk);
    chk("t6_valid", u_out_valid, 1);
    chk("t6_last", u_out_last, 1);
    chk("t6_row", u_out_row, 0);
    chk("t6_data", u_out_data[0], 24'hABCDEF);
    chk("t6_in_ready", u_in_ready, 1);
    step();
    @(negedge clk);
    chk("t6_frame_done", u_frame_done, 1);
    chk("t6_idle", u_out_valid, 0);
    step();
    @(negedge clk);
    chk("t6_done_pulse", u_frame_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
